board_ram_arbiter: RTL



---
 rtl/board_ram_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/board_ram_arbiter.sv
// Arbitrates the single-port board BRAM between the red/blue player writers and the
// frame renderer's full-board read scan. Define BOARD_COLLISION_EN to paint shared cells yellow.
module board_ram_arbiter #(
  parameter int GRID_W = 16,
  parameter int CELLS  = GRID_W * GRID_W,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              red_req,
  input  logic [3:0]        red_X,
  input  logic [3:0]        red_Y,
  output logic              red_ack,
  input  logic              blue_req,
  input  logic [3:0]        blue_X,
  input  logic [3:0]        blue_Y,
  output logic              blue_ack,
  input  logic              scan_req,
  output logic              scan_busy,
  output logic              scan_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [2:0]        mem_data,
  output logic              mem_wren,
  output logic              mem_rden,
  input  logic [2:0]        mem_q,
  output logic              pix_valid,
  output logic [ADDR_W-1:0] pix_index,
  output logic [2:0]        pix_colour
);

  localparam logic [2:0] RED_COLOUR    = 3'b100;
  localparam logic [2:0] BLUE_COLOUR   = 3'b001;
  localparam logic [2:0] YELLOW_COLOUR = 3'b110;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    SCAN,
    DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] scan_cnt_q, scan_cnt_d;
  logic              scan_pending_q, scan_pending_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic              pix_valid_q, pix_valid_d;
  logic [ADDR_W-1:0] pix_index_q, pix_index_d;

  logic [ADDR_W-1:0] red_cell;
  logic [ADDR_W-1:0] blue_cell;
  logic [2:0]        own_colour;

  assign red_cell   = ADDR_W'({red_Y, red_X});
  assign blue_cell  = ADDR_W'({blue_Y, blue_X});
  assign own_colour = grant_q ? BLUE_COLOUR : RED_COLOUR;

  // Grant flags encode 1 = blue, 0 = red; last_grant resets to blue so red wins the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      scan_cnt_q     <= '0;
      scan_pending_q <= 1'b0;
      last_grant_q   <= 1'b1;
      grant_q        <= 1'b0;
      pix_valid_q    <= 1'b0;
      pix_index_q    <= '0;
    end else begin
      state_q        <= state_d;
      scan_cnt_q     <= scan_cnt_d;
      scan_pending_q <= scan_pending_d;
      last_grant_q   <= last_grant_d;
      grant_q        <= grant_d;
      pix_valid_q    <= pix_valid_d;
      pix_index_q    <= pix_index_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    scan_cnt_d     = scan_cnt_q;
    scan_pending_d = scan_pending_q | scan_req;
    last_grant_d   = last_grant_q;
    grant_d        = grant_q;
    pix_valid_d    = 1'b0;
    pix_index_d    = '0;
    red_ack        = 1'b0;
    blue_ack       = 1'b0;
    scan_busy      = 1'b0;
    scan_done      = 1'b0;
    mem_address    = '0;
    mem_data       = 3'b000;
    mem_wren       = 1'b0;
    mem_rden       = 1'b0;

    case (state_q)
      IDLE: begin
        if (scan_req || scan_pending_q) begin
          state_d        = SCAN;
          scan_pending_d = 1'b0;
          scan_cnt_d     = '0;
        end else if (red_req && blue_req) begin
          grant_d = ~last_grant_q;
          state_d = WRITE;
        end else if (red_req) begin
          grant_d = 1'b0;
          state_d = WRITE;
        end else if (blue_req) begin
          grant_d = 1'b1;
          state_d = WRITE;
        end
      end

      WRITE: begin
        mem_wren     = 1'b1;
        mem_address  = grant_q ? blue_cell : red_cell;
`ifdef BOARD_COLLISION_EN
        mem_data     = (red_cell == blue_cell) ? YELLOW_COLOUR : own_colour;
`else
        mem_data     = own_colour;
`endif
        red_ack      = ~grant_q;
        blue_ack     = grant_q;
        last_grant_d = grant_q;
        state_d      = IDLE;
      end

      SCAN: begin
        scan_busy   = 1'b1;
        mem_rden    = 1'b1;
        mem_address = scan_cnt_q;
        pix_valid_d = 1'b1;
        pix_index_d = scan_cnt_q;
        if (scan_cnt_q == LAST_CELL) begin
          scan_cnt_d = '0;
          state_d    = DRAIN;
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end

      DRAIN: begin
        scan_busy = 1'b1;
        scan_done = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // The BRAM output register already aligns mem_q with pix_index, so colour is only gated.
  assign pix_valid  = pix_valid_q;
  assign pix_index  = pix_index_q;
  assign pix_colour = pix_valid_q ? mem_q : 3'b000;

endmodule
